// File: rtl/mem_stage_pkg.sv
// Shared widths, encodings and bus layouts for the memory-access stage.
package mem_stage_pkg;

    localparam int unsigned ES_TO_MS_BUS_WD = 109;
    localparam int unsigned MS_TO_WS_BUS_WD = 73;
    localparam int unsigned MS_TO_DS_BUS_WD = 39;

    typedef enum logic [2:0] {
        LOAD_OP_LW   = 3'd0,
        LOAD_OP_LB   = 3'd1,
        LOAD_OP_LBU  = 3'd2,
        LOAD_OP_LH   = 3'd3,
        LOAD_OP_LHU  = 3'd4,
        LOAD_OP_LWL  = 3'd5,
        LOAD_OP_LWR  = 3'd6,
        LOAD_OP_NONE = 3'd7
    } load_op_e;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_DONE = 2'd2
    } ms_state_e;

    typedef struct packed {
        load_op_e    load_op;
        logic        mem_req;
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] rt_value;
        logic [31:0] pc;
    } es_to_ms_bus_t;

    typedef struct packed {
        logic [3:0]  rf_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_bus_t;

    typedef struct packed {
        logic        fwd_valid;
        logic        fwd_ready;
        logic [4:0]  dest;
        logic [31:0] result;
    } ms_to_ds_bus_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Combinational load-data alignment and extension, including LWL/LWR merge
// with the per-byte register-file write strobe.
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  load_op_e    i_load_op,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_rt_value,
    input  logic [3:0]  i_rf_we,
    output logic [31:0] o_result_c,
    output logic [3:0]  o_we_c
);

    logic [1:0]  w_a;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_a    = i_alu_result[1:0];
    assign w_half = w_a[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        w_byte = i_rdata[7:0];
        case (w_a)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    always_comb begin
        o_result_c = i_alu_result;
        o_we_c     = i_rf_we;
        case (i_load_op)
            LOAD_OP_LW:  o_result_c = i_rdata;
            LOAD_OP_LB:  o_result_c = {{24{w_byte[7]}}, w_byte};
            LOAD_OP_LBU: o_result_c = {24'd0, w_byte};
            LOAD_OP_LH:  o_result_c = {{16{w_half[15]}}, w_half};
            LOAD_OP_LHU: o_result_c = {16'd0, w_half};
            LOAD_OP_LWL: begin
                case (w_a)
                    2'd0: begin o_result_c = {i_rdata[7:0],  i_rt_value[23:0]}; o_we_c = 4'b1000; end
                    2'd1: begin o_result_c = {i_rdata[15:0], i_rt_value[15:0]}; o_we_c = 4'b1100; end
                    2'd2: begin o_result_c = {i_rdata[23:0], i_rt_value[7:0]};  o_we_c = 4'b1110; end
                    default: begin o_result_c = i_rdata; o_we_c = 4'b1111; end
                endcase
            end
            LOAD_OP_LWR: begin
                case (w_a)
                    2'd1: begin o_result_c = {i_rt_value[31:24], i_rdata[31:8]};  o_we_c = 4'b0111; end
                    2'd2: begin o_result_c = {i_rt_value[31:16], i_rdata[31:16]}; o_we_c = 4'b0011; end
                    2'd3: begin o_result_c = {i_rt_value[31:8],  i_rdata[31:24]}; o_we_c = 4'b0001; end
                    default: begin o_result_c = i_rdata; o_we_c = 4'b1111; end
                endcase
            end
            default: begin
                o_result_c = i_alu_result;
                o_we_c     = i_rf_we;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, waits for its SRAM
// response, aligns load data and hands off to write-back with bypass to decode.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata
);

    es_to_ms_bus_t w_es_bus;
    ms_to_ws_bus_t w_ws_bus;
    ms_to_ds_bus_t w_ds_bus;

    ms_state_e   r_state;
    ms_state_e   w_state_nxt;
    logic        r_ms_valid;
    load_op_e    r_load_op;
    logic [3:0]  r_rf_we;
    logic [4:0]  r_dest;
    logic [31:0] r_alu_result;
    logic [31:0] r_rt_value;
    logic [31:0] r_pc;
    logic [31:0] r_rdata_buf;

    logic        w_data_ok_wait;
    logic        w_ready_go;
    logic        w_accept;
    logic        w_handoff;
    logic [31:0] w_rdata;
    logic [31:0] w_result;
    logic [3:0]  w_we;

    assign w_es_bus = es_to_ms_bus_t'(es_to_ms_bus);

    // Responses only count while a request is outstanding; strays are dropped.
    assign w_data_ok_wait = (r_state == MS_WAIT) && data_sram_data_ok;
    assign w_ready_go     = (r_state == MS_IDLE) || (r_state == MS_DONE) || w_data_ok_wait;
    assign ms_allowin     = !r_ms_valid || (w_ready_go && ws_allowin);
    assign ms_to_ws_valid = r_ms_valid && w_ready_go;
    assign w_accept       = es_to_ms_valid && ms_allowin;
    assign w_handoff      = ms_to_ws_valid && ws_allowin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= MS_IDLE;
            r_ms_valid <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            MS_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_es_bus.mem_req ? MS_WAIT : MS_IDLE;
                end
            end
            MS_WAIT: begin
                if (data_sram_data_ok) begin
                    if (w_accept) begin
                        w_state_nxt = w_es_bus.mem_req ? MS_WAIT : MS_IDLE;
                    end else if (w_handoff) begin
                        w_state_nxt = MS_IDLE;
                    end else begin
                        w_state_nxt = MS_DONE;
                    end
                end
            end
            MS_DONE: begin
                if (w_accept) begin
                    w_state_nxt = w_es_bus.mem_req ? MS_WAIT : MS_IDLE;
                end else if (w_handoff) begin
                    w_state_nxt = MS_IDLE;
                end
            end
            default: w_state_nxt = MS_IDLE;
        endcase
    end

    // Payload and response buffer carry no reset; they are qualified by valid/state.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_load_op    <= w_es_bus.load_op;
            r_rf_we      <= w_es_bus.rf_we;
            r_dest       <= w_es_bus.dest;
            r_alu_result <= w_es_bus.alu_result;
            r_rt_value   <= w_es_bus.rt_value;
            r_pc         <= w_es_bus.pc;
        end
        if (w_data_ok_wait) begin
            r_rdata_buf <= data_sram_rdata;
        end
    end

    assign w_rdata = (r_state == MS_WAIT) ? data_sram_rdata : r_rdata_buf;

    mem_stage_load_align u_load_align (
        .i_load_op    (r_load_op),
        .i_alu_result (r_alu_result),
        .i_rdata      (w_rdata),
        .i_rt_value   (r_rt_value),
        .i_rf_we      (r_rf_we),
        .o_result_c   (w_result),
        .o_we_c       (w_we)
    );

    always_comb begin
        w_ws_bus.rf_we        = w_we;
        w_ws_bus.dest         = r_dest;
        w_ws_bus.final_result = w_result;
        w_ws_bus.pc           = r_pc;

        w_ds_bus.fwd_valid = r_ms_valid && (|w_we);
        w_ds_bus.fwd_ready = w_ready_go;
        w_ds_bus.dest      = r_dest;
        w_ds_bus.result    = w_result;
    end

    assign ms_to_ws_bus = w_ws_bus;
    assign ms_to_ds_bus = w_ds_bus;

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline, between the execute stage and the write-back stage. It latches an instruction from execute, waits for the data-SRAM response when that instruction issued a memory request, and aligns and extends load data, including LWL/LWR merge with a per-byte write strobe. It drives the write-back bus under the valid/allowin handshake and supplies a bypass bus to decode.

## Interface
- Parameters: none; widths come from shared macros `ES_TO_MS_BUS_WD` = 109, `MS_TO_WS_BUS_WD` = 73, `MS_TO_DS_BUS_WD` = 39.
- Ports:
- `clk` in 1: the only clock. Everything samples on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `ws_allowin` in 1: write-back stage can accept this cycle.
- `ms_allowin` out 1: this stage can accept from execute.
- `es_to_ms_valid` in 1: execute offers an instruction.
- `es_to_ms_bus` in 109, fields from MSB down:
  - `load_op[108:106]`
  - `mem_req[105]`
  - `rf_we[104:101]`
  - `dest[100:96]`
  - `alu_result[95:64]`
  - `rt_value[63:32]`
  - `pc[31:0]`
- `ms_to_ws_valid` out 1: instruction ready for write-back.
- `ms_to_ws_bus` out 73, fields:
  - `rf_we[72:69]`
  - `dest[68:64]`
  - `final_result[63:32]`
  - `pc[31:0]`
- `ms_to_ds_bus` out 39, fields:
  - `fwd_valid[38]`
  - `fwd_ready[37]`
  - `dest[36:32]`
  - `result[31:0]`
- `data_sram_data_ok` in 1: response strobe for this stage's outstanding request.
- `data_sram_rdata` in 32: read data, valid while `data_sram_data_ok` is high.

## Operation
- `load_op` encodings:
  - 0: LW
  - 1: LB
  - 2: LBU
  - 3: LH
  - 4: LHU
  - 5: LWL
  - 6: LWR
  - 7: non-load
- Stores carry `mem_req`=1 with `load_op`=7. The result is `alu_result` and `rf_we` stays as given (0).
- Let `a` = `alu_result[1:0]`. The selection is little-endian.
  - LB/LBU: byte `a`, sign- or zero-extended.
  - LH/LHU: the half selected by `a[1]`, sign- or zero-extended.
  - LW: `rdata` unchanged.
  - LWL:
    - a=0: {rdata[7:0], rt[23:0]}, we 1000
    - a=1: {rdata[15:0], rt[15:0]}, we 1100
    - a=2: {rdata[23:0], rt[7:0]}, we 1110
    - a=3: rdata, we 1111
  - LWR:
    - a=0: rdata, we 1111
    - a=1: {rt[31:24], rdata[31:8]}, we 0111
    - a=2: {rt[31:16], rdata[31:16]}, we 0011
    - a=3: {rt[31:8], rdata[31:24]}, we 0001
  - For every other load, `rf_we` passes through.
- The data source is the live `data_sram_rdata` in the `data_ok` cycle, and the held buffer afterwards.
- FSM states:
  - IDLE: no instruction, or an instruction without `mem_req`.
  - WAIT: waiting for the response.
  - DONE: response captured into a 32-bit holding register.
- FSM transitions:
  - Acceptance with `mem_req`=1 goes to WAIT. Acceptance with `mem_req`=0 goes to IDLE.
  - WAIT with `data_ok`=1 goes to DONE and captures `rdata`. If `ms_to_ws_valid && ws_allowin` in that same cycle, it goes to IDLE, or to WAIT if a new mem instruction is accepted at the same time.
  - DONE with handoff goes to IDLE, or to WAIT when a new mem instruction is accepted at the same time.
- `ms_ready_go` = IDLE, or DONE, or (WAIT && `data_ok`).
- Handshake equations:
  - `ms_allowin` = !`ms_valid` || (`ms_ready_go` && `ws_allowin`)
  - `ms_to_ws_valid` = `ms_valid` && `ms_ready_go`
- The bus register loads only on `es_to_ms_valid && ms_allowin`.
- `ms_valid` updates to `es_to_ms_valid` whenever `ms_allowin` is high.
- Bypass fields:
  - `fwd_valid` = `ms_valid` && |`rf_we`
  - `fwd_ready` = `ms_ready_go`
  - `dest` and `result` carry the current values.
- A `data_ok` outside WAIT is ignored and flagged by a bench assertion.

## Timing
- Reset values:
  - `ms_valid`=0, state IDLE.
  - `ms_allowin`=1, `ms_to_ws_valid`=0, `fwd_valid`=0.
  - Bus and holding registers are undefined.
- Non-memory instruction: offered to write-back the cycle after acceptance, so latency is 1 cycle.
- Memory instruction with `data_ok` k cycles after acceptance (k≥0): `ms_to_ws_valid` rises in the `data_ok` cycle.
  - The data path from `data_ok` to `ms_to_ws_bus` is combinational in that cycle.
- `ws_allowin` low in the `data_ok` cycle: the FSM enters DONE and outputs hold stable from the buffer until accepted.
- Back-to-back acceptance with no bubble is required when `ws_allowin`=1.
- Reset asserted in WAIT aborts the instruction. Any late response is discarded, because the SRAM bridge is reset from the same source.

## Structure
- In `mycpu.h`:
  - the bus-width macros
  - `LOAD_OP_*` encodings
  - FSM state encodings `MS_IDLE`/`MS_WAIT`/`MS_DONE`
- Sub-module `load_align`: purely combinational. It maps (`load_op`, `a`, `rdata`, `rt_value`, `rf_we`) to (`final_result`, strobe).

## Test plan
- Reset mid-WAIT: assert `reset` → `ms_valid`=0, `ms_allowin`=1, `fwd_valid`=0 immediately. After release, a stray `data_ok` produces no output.
- LW, addr 0x1000, `data_ok` 3 cycles later with rdata 0x8899AABB → `ms_to_ws_valid` rises in the `data_ok` cycle, result 0x8899AABB, we 1111.
- LB at a=3, rdata 0x80112233 → 0xFFFFFF80. LBU at the same address → 0x00000080. LHU at a=2 → 0x00008011.
- LWL at a=1, rdata 0xAABBCCDD, rt 0x11223344 → 0xCCDD3344, we 1100. LWR at a=2 with the same data → 0x1122AABB, we 0011.
- `ws_allowin` low for 2 cycles around `data_ok`:
  - The result holds steady and is delivered exactly once.
  - Then a back-to-back ADD → SW → ADD stream completes with no bubbles apart from the SW wait.
- Forwarding: during WAIT for a load to r5, `ms_to_ds_bus` = {1, 0, 5, x}. In the `data_ok` cycle, `fwd_ready`=1 and the result is valid.
